// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder used as the serial add step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, result published on DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_d;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // The new sum bit enters at the MSB so after WIDTH steps bit 0 holds the LSB.
  assign res_d = (res_q >> 1'b1) | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          res_q   <= res_d;
          carry_q <= fa_c;
          a_q     <= a_q >> 1'b1;
          b_q     <= b_q >> 1'b1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            sum_q   <= res_d;
            cout_q  <= fa_c;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit directed/random ops and an exhaustive 4-bit sweep.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [8:0] exp8_q[$];
  int         lat8_q[$];
  logic [4:0] exp4_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: the addition itself, done with plain wide arithmetic.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  // Monitor for the 8-bit instance.
  logic [8:0] last8;
  logic       prev_done8;
  int         run8;
  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = 9'd0; prev_done8 = 1'b0; run8 = 0;
    end else begin
      if (done8) begin
        chk("done8_single_cycle", prev_done8, 0);
        chk("done8_expected", exp8_q.size() > 0, 1);
        if (exp8_q.size() > 0) begin
          chk("result8", {cout8, sum8}, exp8_q.pop_front());
          chk("latency8", cyc - lat8_q.pop_front(), 9);
        end
        last8 = {cout8, sum8};
      end else begin
        chk("hold8", {cout8, sum8}, last8);
      end
      if (busy8) run8++;
      else if (run8 > 0) begin
        chk("busy8_len", run8, 9);
        run8 = 0;
      end
      prev_done8 = done8;
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      chk("done4_expected", exp4_q.size() > 0, 1);
      if (exp4_q.size() > 0) chk("result4", {cout4, sum4}, exp4_q.pop_front());
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 40) begin @(negedge clk); n++; end
    if (busy8) chk("idle8_timeout", busy8, 0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (busy4 && n < 40) begin @(negedge clk); n++; end
    if (busy4) chk("idle4_timeout", busy4, 0);
  endtask

  // Issue one 8-bit op; operands are scrambled after acceptance, optionally with a stray start.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit poke);
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp8_q.push_back(ref8(a, b, c));
    lat8_q.push_back(cyc);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    if (poke) begin
      repeat (3) @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
    end
    @(negedge clk);
    wait_idle8();
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
    wait_idle4();
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    exp4_q.push_back(ref4(a, b, c));
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    @(negedge clk);
    wait_idle4();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] e;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_result8", {cout8, sum8}, 9'd0);
    chk("reset_result4", {busy4, done4, cout4, sum4}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(8'h0F, 8'h01, 1'b0, 1'b0);
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0);
    issue8(8'h80, 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // Abort mid-shift with a reset, then a fresh add.
    wait_idle8();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_result8", {cout8, sum8}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(8'h12, 8'h34, 1'b0, 1'b0);

    // start held high for 40 cycles: accepts every 10 cycles.
    wait_idle8();
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
    e = ref8(ra, rb, rc);
    for (int i = 0; i < 4; i++) begin
      exp8_q.push_back(e);
      lat8_q.push_back(cyc + 10 * i);
    end
    repeat (40) @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    wait_idle8();

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue4(4'(ia), 4'(ib), 1'(ic));

    repeat (3) @(negedge clk);
    chk("pending8", exp8_q.size(), 0);
    chk("pending4", exp4_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result sum; held stable from done until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1 bit: result carry-out; held with sum.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE, start=1 SHALL count as accepted: capture a, b, cin into the A shift register, B shift register and carry register; clear the bit counter; go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL add A[0], B[0] and the carry register in one 1-bit full-adder step; shift the sum bit into the result register MSB-first (right shift); update the carry register; right-shift A and B; increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; on the cycle the counter reaches WIDTH-1, the next state SHALL be DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, sum SHALL equal (a+b+cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of a+b+cin; the next state SHALL be IDLE.
REQ-017 Latency SHALL be WIDTH+1 cycles from the start-accept edge to the done-high cycle; throughput SHALL be one addition per WIDTH+2 cycles.
REQ-018 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored, with no queuing and no effect on the addition in flight.
REQ-020 start held high continuously SHALL be accepted again in the first IDLE cycle after DONE.
REQ-021 Operand changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 sum and cout SHALL only change at the transition into DONE, and SHALL not be visible as partial results; the shifting result register SHALL be internal.
REQ-023 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-024 rst_n=0 SHALL immediately force: state to IDLE; busy, done, sum, cout, carry register, counter and shift registers to 0.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL begin a fresh addition.

Structure
REQ-026 The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package/header serial_adder_pkg.
REQ-027 The 1-bit add step SHALL be a sub-module full_adder (ports a, b, cin, s, cout; purely combinational), instantiated once.
REQ-028 Unused state encoding 2'd3 SHALL return to IDLE on the next clock.

Verification
REQ-029 WIDTH=8: a=8'h0F, b=8'h01, cin=0, pulse start -> done exactly 9 cycles later; sum=8'h10, cout=0.
REQ-030 WIDTH=8: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; busy high for exactly 9 cycles.
REQ-031 WIDTH=8: a=8'h80, b=8'h80, cin=0, then change a/b to 8'h00 during SHIFT and pulse start again -> sum=8'h00, cout=1; exactly one done pulse.
REQ-032 Drop rst_n at SHIFT cycle 4 of an 8'hAA+8'h55 add -> outputs 0 at once, no done; then 8'h12+8'h34 -> sum=8'h46, cout=0.
REQ-033 start held high for 40 cycles, WIDTH=8 -> done pulses 10 cycles apart; exhaustive 4-bit sweep (WIDTH=4, all a, b, cin) matches a+b+cin.
